// File: rtl/pixel_pkg.sv
// Shared types for the edge-filter pixel sink: pixel width, pixel type and writer states.
package pixel_pkg;

    localparam int unsigned PIX_W = 4;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE
    } wr_state_t;

    // Counter width for 0..n-1, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_frame_writer_raster.sv
// Column/row/linear-address counters for one raster-order frame; wraps to 0 after the last pixel.
module raster_counter
    import pixel_pkg::*;
#(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    localparam int unsigned COL_W = clog2_min1(IMG_W);
    localparam int unsigned ROW_W = clog2_min1(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign last_c = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

    // Linear address advances alongside col/row so no row*IMG_W multiply is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clr || (en && last_c)) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (en) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/edge_frame_writer.sv
// Captures one frame of filtered pixels on start and writes it linearly into the frame buffer.
module edge_frame_writer
    import pixel_pkg::*;
#(
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned SKIP_PIX = 0,
    localparam int unsigned ADDR_W  = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  pixel_t            pixel_in,
    input  logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output pixel_t            wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned SKIP_W = clog2_min1(SKIP_PIX);

    wr_state_t         state;
    logic [SKIP_W-1:0] skip_cnt;
    logic              cnt_clr;
    logic              cnt_en;
    logic              last_c;
    logic [ADDR_W-1:0] cur_addr;

    assign cnt_clr = (state == IDLE) && start;
    assign cnt_en  = (state == CAPTURE) && in_ready;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .addr   (cur_addr),
        .last_c (last_c)
    );

    // Writer FSM with registered write port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            skip_cnt   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A pixel coinciding with start is dropped; capture begins next cycle
                    if (start) begin
                        state    <= (SKIP_PIX > 0) ? SKIP : CAPTURE;
                        skip_cnt <= '0;
                        overrun  <= 1'b0;
                        busy     <= 1'b1;
                    end else if (in_ready) begin
                        overrun <= 1'b1;
                    end
                end
                SKIP: begin
                    if (in_ready) begin
                        if (skip_cnt == SKIP_W'(SKIP_PIX - 1)) begin
                            state    <= CAPTURE;
                            skip_cnt <= '0;
                        end else begin
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (in_ready) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cur_addr;
                        wr_data <= pixel_in;
                        if (last_c) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Directed bench for edge_frame_writer: pixel-index model checked every cycle plus literal write logs.
module tb_edge_frame_writer;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int SKIP   = 2;
    localparam int ADDR_W = $clog2(W * H);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        pixel_in = '0;
    logic              in_ready = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [7:0]        frame_cnt;

    logic              start0 = 1'b0;
    logic [3:0]        pix0 = '0;
    logic              rdy0 = 1'b0;
    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [3:0]        wr_data0;
    logic              busy0;
    logic              frame_done0;
    logic              overrun0;
    logic [7:0]        frame_cnt0;

    always #5 clk = ~clk;

    edge_frame_writer #(.IMG_W(W), .IMG_H(H), .SKIP_PIX(SKIP)) dut (
        .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    edge_frame_writer #(.IMG_W(W), .IMG_H(H), .SKIP_PIX(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pixel_in(pix0), .in_ready(rdy0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0),
        .frame_done(frame_done0), .overrun(overrun0), .frame_cnt(frame_cnt0)
    );

    int tests = 0;
    int fails = 0;
    int wlog[$];

    // Model: a frame is the stream of valid pixels after start; pixel k lands at address k-SKIP
    bit         m_armed = 1'b0;
    int         m_seen  = 0;
    bit         m_ovr   = 1'b0;
    logic [7:0] m_frames = '0;
    int         m_addr  = 0;
    logic [3:0] m_data  = '0;
    bit         e_wr_en = 1'b0;
    bit         e_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit v, input logic [3:0] p);
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        if (r) begin
            m_armed = 1'b0; m_seen = 0; m_ovr = 1'b0; m_frames = '0; m_addr = 0; m_data = '0;
        end else if (m_armed) begin
            if (v) begin
                if (m_seen >= SKIP) begin
                    e_wr_en = 1'b1;
                    m_addr  = m_seen - SKIP;
                    m_data  = p;
                    if (m_addr == W * H - 1) begin
                        e_done   = 1'b1;
                        m_frames = m_frames + 8'd1;
                        m_armed  = 1'b0;
                    end
                end
                m_seen++;
            end
        end else if (s) begin
            m_armed = 1'b1;
            m_seen  = 0;
            m_ovr   = 1'b0;
        end else if (v) begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("wr_en", 32'(wr_en), 32'(e_wr_en));
        check("wr_addr", 32'(wr_addr), 32'(m_addr));
        check("wr_data", 32'(wr_data), 32'(m_data));
        check("busy", 32'(busy), 32'(m_armed));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        if (wr_en) wlog.push_back(int'(wr_addr) * 16 + int'(wr_data));
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [3:0] p);
        rst = r; start = s; in_ready = v; pixel_in = p;
        model(r, s, v, p);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Standard frame: 12 writes, address i carrying pixel value i+2
    task automatic check_std_log(input string name);
        check({name, "_len"}, 32'(wlog.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            check(name, (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF, 32'(i * 16 + i + 2));
        wlog.delete();
    endtask

    initial begin
        // 1: reset with random inputs, then idle
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
        wlog.delete();

        // 2: contiguous frame
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check_std_log("t2_log");
        check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // 3: valid every other cycle
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'(i));
            step(1'b0, 1'b0, 1'b0, 4'hF);
        end
        check_std_log("t3_log");
        check("t3_frame_cnt", 32'(frame_cnt), 32'd2);

        // 4: overrun while idle, cleared by start; start pulse mid-capture ignored
        step(1'b0, 1'b0, 1'b1, 4'd5);
        check("t4_overrun_set", 32'(overrun), 32'd1);
        check("t4_no_write", 32'(wr_en), 32'd0);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check("t4_overrun_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 14; i++) step(1'b0, (i == 6), 1'b1, 4'(i + 2));
        check("t4_frame_cnt", 32'(frame_cnt), 32'd3);
        wlog.delete();

        // 5: start with coincident pixel, then back-to-back start on frame_done
        step(1'b0, 1'b1, 1'b1, 4'd9);
        check("t5_no_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        check("t5_done", 32'(frame_done), 32'd1);
        check_std_log("t5_log");
        step(1'b0, 1'b1, 1'b0, 4'd0);
        check("t5_b2b_busy", 32'(busy), 32'd1);

        // 6: async reset right after the write of address 5
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'(i));
        check("t6_pre_addr", 32'(wr_addr), 32'd5);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cnt", 32'(frame_cnt), 32'd0);
        model(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        wlog.delete();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 14; i++) step(1'b0, (i == 4 || i == 9), 1'b1, 4'(i));
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check_std_log("t6_log");
        check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

        // 6b: SKIP_PIX=0 instance writes the first pixel to address 0
        start0 = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("s0_busy", 32'(busy0), 32'd1);
        start0 = 1'b0; rdy0 = 1'b1; pix0 = 4'd7;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("s0_wr_en_a", 32'(wr_en0), 32'd1);
        check("s0_addr_a", 32'(wr_addr0), 32'd0);
        check("s0_data_a", 32'(wr_data0), 32'd7);
        pix0 = 4'd8;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("s0_addr_b", 32'(wr_addr0), 32'd1);
        check("s0_data_b", 32'(wr_data0), 32'd8);
        rdy0 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check("s0_wr_en_idle", 32'(wr_en0), 32'd0);
        check("s0_hold_addr", 32'(wr_addr0), 32'd1);
        check("s0_overrun", 32'(overrun0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
